// File: rtl/elbeth_rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : elbeth_rf_wb_arbiter
// Purpose  : Shares the register-file write port between the execute stage
//            (fixed priority) and a FIFO-buffered lsu writeback stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elbeth_rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AGE_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exs_wb_valid,
  input  logic [4:0]  exs_rd_addr,
  input  logic [31:0] exs_rd_data,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_rd_addr,
  input  logic [31:0] lsu_rd_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        ctrl_w_enable,
  output logic        stall_req,
  output logic [31:0] pending_mask,
  output logic        err_collision
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [4:0]       r_q_addr [FIFO_DEPTH];
  logic [31:0]      r_q_data [FIFO_DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic [AGE_W-1:0] r_age;
  logic             r_stall;
  logic             r_err;
  logic             r_wen;
  logic             r_from_lsu;
  logic [4:0]       r_rd_addr;
  logic [31:0]      r_rd_data;

  logic             w_ready;
  logic             w_push;
  logic             w_store;
  logic             w_empty;
  logic             w_pop;
  logic [31:0]      w_mask;

  // Ready looks only at the registered count so it never depends on a same-cycle pop.
  always_comb begin
    w_ready = (r_count < c_CW'(FIFO_DEPTH)) && !rst;
    w_push  = lsu_wb_valid && w_ready;
    w_store = w_push && (lsu_rd_addr != 5'd0);
    w_empty = (r_count == '0);
    w_pop   = !exs_wb_valid && !w_empty;
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_q_addr[r_wptr] <= lsu_rd_addr;
      r_q_data[r_wptr] <= lsu_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_age      <= '0;
      r_stall    <= 1'b0;
      r_err      <= 1'b0;
      r_wen      <= 1'b0;
      r_from_lsu <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + c_CW'(w_store) - c_CW'(w_pop);

      if (w_empty || w_pop)
        r_age <= '0;
      else if (r_age != '1)
        r_age <= r_age + 1'b1;

      r_stall <= (r_age >= AGE_W'(STARVE_LIMIT));
      r_err   <= r_err | (r_stall & exs_wb_valid);

      if (exs_wb_valid) begin
        r_rd_addr  <= exs_rd_addr;
        r_rd_data  <= exs_rd_data;
        r_wen      <= (exs_rd_addr != 5'd0);
        r_from_lsu <= 1'b0;
      end else if (w_pop) begin
        r_rd_addr  <= r_q_addr[r_rptr];
        r_rd_data  <= r_q_data[r_rptr];
        r_wen      <= 1'b1;
        r_from_lsu <= 1'b1;
      end else begin
        r_wen      <= 1'b0;
        r_from_lsu <= 1'b0;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, c_PW'(i) - r_rptr} < r_count)
        w_mask[r_q_addr[i]] = 1'b1;
    end
    if (r_wen && r_from_lsu)
      w_mask[r_rd_addr] = 1'b1;
    w_mask[0] = 1'b0;
  end

  assign lsu_wb_ready  = w_ready;
  assign rd_addr       = r_rd_addr;
  assign rd_data       = r_rd_data;
  assign ctrl_w_enable = r_wen;
  assign stall_req     = r_stall;
  assign err_collision = r_err;
  assign pending_mask  = w_mask;

endmodule

`default_nettype wire

// File: doc/elbeth_rf_wb_arbiter.md
Name: elbeth_rf_wb_arbiter

Overview:
Sequences the single write port of elbeth_register_file between two writeback sources. The first source is the execute stage (exs), which has fixed priority and is never back-pressured. The second is the load/store or long-latency unit (lsu), which uses a valid/ready handshake and is buffered in a small FIFO. The block drives rd_addr/rd_data/ctrl_w_enable of the register file, and exports a pending-write mask and a starvation stall request to the decode/hazard logic.

Parameters:
FIFO_DEPTH, 2, number of lsu writeback entries buffered; legal values 2 or 4.
STARVE_LIMIT, 4, cycles the FIFO head may wait before stall_req asserts; range 1..7.
AGE_W, 3, width of the head-age counter; must hold STARVE_LIMIT.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous active-high reset.
exs_wb_valid  in  1  execute stage has a writeback this cycle.
exs_rd_addr  in  5  execute destination register.
exs_rd_data  in  32  execute result.
lsu_wb_valid  in  1  lsu offers a writeback.
lsu_wb_ready  out  1  arbiter accepts the lsu writeback this cycle.
lsu_rd_addr  in  5  lsu destination register.
lsu_rd_data  in  32  lsu result.
rd_addr  out  5  register file write address (registered).
rd_data  out  32  register file write data (registered).
ctrl_w_enable  out  1  register file write enable (registered).
stall_req  out  1  request that the pipeline hold exs writebacks for one slot.
pending_mask  out  32  bit i = a write to xi is buffered or in flight from lsu.
err_collision  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty; age=0; rd_addr=0, rd_data=0, ctrl_w_enable=0, stall_req=0, err_collision=0, pending_mask=0. lsu_wb_ready=0 while rst is high. Any buffered writes are discarded when rst is asserted mid-operation.
- lsu_wb_ready = (count < FIFO_DEPTH) && !rst. It depends only on the registered count, never on a same-cycle pop.
- Push: on lsu_wb_valid && lsu_wb_ready. If lsu_rd_addr==0, the transfer completes but nothing is stored (x0 discard).
- Arbitration per cycle N, with the result visible on the outputs after edge N+1:
  - If exs_wb_valid: rd_addr/rd_data load the exs values; ctrl_w_enable = (exs_rd_addr != 0).
  - Else if FIFO is non-empty: pop the head; rd_addr/rd_data load the head; ctrl_w_enable=1.
  - Else: ctrl_w_enable=0; rd_addr/rd_data hold their previous values.
- Latency: exs write is 1 cycle. An lsu entry pushed into an empty FIFO with exs idle reaches the write port 2 cycles after acceptance (no same-cycle bypass).
- An exs write is never dropped or delayed.
- The FIFO preserves lsu order. exs and lsu ordering to the same rd is not enforced here; decode uses pending_mask to avoid WAW/RAW against lsu.
- Simultaneous push and pop in one cycle is legal when count < FIFO_DEPTH; count is unchanged.
- Age counter:
  - Reset to 0 when the FIFO is empty or the head is popped.
  - Otherwise increments, saturating at 2^AGE_W-1.
- stall_req is registered and =1 when age >= STARVE_LIMIT. It deasserts on the edge after the head pops.
- err_collision sets when stall_req && exs_wb_valid (the pipeline ignored the request). exs still wins in that cycle. Only rst clears the flag.
- pending_mask: OR of one-hot decodes of all valid FIFO entry addresses, plus the output register address when the current ctrl_w_enable came from a lsu pop. Bit 0 is always 0. The mask is combinational from the registered state.
- Wrap-around: read/write pointers are modulo FIFO_DEPTH. Full/empty are decided from a separate count register (0..FIFO_DEPTH).

Test Plan:
- exs only: exs_wb_valid=1, addr=5, data=0xDEADBEEF at cycle 1 -> cycle 2 shows rd_addr=5, rd_data=0xDEADBEEF, ctrl_w_enable=1, lsu_wb_ready stays 1.
- lsu only: push addr=7, data=0x12 at cycle 1 with exs idle -> pending_mask[7]=1 from cycle 2; write appears at cycle 3; pending_mask=0 at cycle 4.
- Fill and back-pressure: exs_wb_valid held 1; push 3 lsu entries (addr 1,2,3) with DEPTH=2 -> third push stalls (ready=0). After exs drops, writes 1 then 2 in consecutive cycles, then 3 is accepted.
- Starvation: FIFO holds addr 9 while exs is valid every cycle, STARVE_LIMIT=4 -> stall_req=1 after 4 waiting cycles. exs then idles -> addr 9 written next cycle; stall_req=0 the cycle after; err_collision=0.
- Collision and x0: keep exs valid while stall_req=1 -> err_collision=1, sticky until rst. Push lsu addr=0 -> accepted, no write, pending_mask unchanged. exs addr=0 -> ctrl_w_enable=0.
- Reset mid-operation: FIFO holding 2 entries, assert rst for 1 cycle -> all outputs 0, no buffered writes ever issued, lsu_wb_ready=1 the cycle after rst drops.
